// File: rtl/vme_reg_responder_if.sv
// VME register-access bus between a bus master and the register responder.
// Strobes, address and write data flow master->slave; completions flow back.
interface vme_reg_responder_if;
  logic [12:2] VMEAddr;
  logic [31:0] VMEWrData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic [31:0] VMERdData;
  logic        VMERdDone;
  logic        VMEWrDone;
  logic        VMERdError;
  logic        VMEWrError;

  modport master (
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    input  VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
  );

  modport slave (
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    output VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
  );
endinterface

// File: rtl/vme_reg_responder.sv
// VME register responder: ID/CTRL/SCRATCH/COUNTER registers plus a mailbox FIFO.
// Writes complete one cycle after the strobe; reads complete RD_WAIT cycles later.
module vme_reg_responder #(
  parameter logic [31:0] ID_VALUE = 32'hCAFE0001,
  parameter int          RD_WAIT  = 2,
  parameter int          FIFO_AW  = 4
) (
  input  logic               Clk,
  input  logic               rst_n,
  vme_reg_responder_if.slave vme,
  output logic               irq_o
);
  localparam int               DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [2:0]       WAIT_LOAD  = 3'(RD_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} rdState_t;
  rdState_t   rdStateReg, rdStateNext;
  logic [2:0] waitCntReg, waitCntNext;

  logic [31:0]        ctrlReg, scratchReg, counterReg;
  logic [31:0]        rdHoldReg, popDataReg;
  logic               rdErrHoldReg, popSelReg;
  logic               wrDoneReg, wrErrorReg, irqReg;
  logic [FIFO_AW-1:0] wrPtrReg, rdPtrReg;
  logic [FIFO_AW:0]   countReg;
  logic [31:0]        fifoMem [DEPTH];

  logic        rdAccept, rdErr, popReq, popValid;
  logic [31:0] rdValue, fifoStat;
  logic        wrErr, ctrlWe, scratchWe, pushReq, pushValid, clrCounter, flushFifo;
  logic        fifoEmpty, fifoFull, mapped;
  logic [2:0]  regSel;

  assign regSel    = vme.VMEAddr[4:2];
  assign mapped    = (vme.VMEAddr[12:5] == '0);
  assign fifoEmpty = (countReg == '0);
  assign fifoFull  = (countReg == FULL_COUNT);

  always_comb begin
    fifoStat             = '0;
    fifoStat[FIFO_AW:0]  = countReg;
    fifoStat[16]         = fifoEmpty;
    fifoStat[17]         = fifoFull;
  end

  // Read decode; error reads always return zero data
  always_comb begin
    rdValue = '0;
    rdErr   = 1'b0;
    popReq  = 1'b0;
    if (!mapped) begin
      rdErr = 1'b1;
    end else begin
      case (regSel)
        3'd0:    rdValue = ID_VALUE;
        3'd1:    rdValue = ctrlReg;
        3'd2:    rdValue = scratchReg;
        3'd3:    rdValue = counterReg;
        3'd5: begin
          popReq = 1'b1;
          rdErr  = fifoEmpty;
        end
        3'd6:    rdValue = fifoStat;
        default: rdErr = 1'b1;
      endcase
    end
  end

  assign rdAccept = vme.VMERdMem && (rdStateReg == IDLE);
  assign popValid = rdAccept && popReq && !fifoEmpty;

  always_comb begin
    wrErr      = 1'b0;
    ctrlWe     = 1'b0;
    scratchWe  = 1'b0;
    pushReq    = 1'b0;
    clrCounter = 1'b0;
    flushFifo  = 1'b0;
    if (!mapped) begin
      wrErr = 1'b1;
    end else begin
      case (regSel)
        3'd1:    ctrlWe    = 1'b1;
        3'd2:    scratchWe = 1'b1;
        3'd4:    pushReq   = 1'b1;
        3'd7: begin
          clrCounter = vme.VMEWrData[0];
          flushFifo  = vme.VMEWrData[1];
        end
        default: wrErr = 1'b1;
      endcase
    end
    // A concurrent pop frees the slot, so a push into a full FIFO is then legal
    if (pushReq && fifoFull && !popValid) wrErr = 1'b1;
  end

  assign pushValid = vme.VMEWrMem && pushReq && !wrErr;

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      ctrlReg      <= '0;
      scratchReg   <= '0;
      counterReg   <= '0;
      wrDoneReg    <= 1'b0;
      wrErrorReg   <= 1'b0;
      wrPtrReg     <= '0;
      rdPtrReg     <= '0;
      countReg     <= '0;
      rdHoldReg    <= '0;
      rdErrHoldReg <= 1'b0;
      popSelReg    <= 1'b0;
      irqReg       <= 1'b0;
    end else begin
      if (vme.VMEWrMem && ctrlWe)    ctrlReg    <= vme.VMEWrData;
      if (vme.VMEWrMem && scratchWe) scratchReg <= vme.VMEWrData;
      if (vme.VMEWrMem && clrCounter) counterReg <= '0;
      else if (ctrlReg[0])            counterReg <= counterReg + 32'd1;
      wrDoneReg  <= vme.VMEWrMem;
      wrErrorReg <= vme.VMEWrMem && wrErr;
      if (vme.VMEWrMem && flushFifo) begin
        wrPtrReg <= '0;
        rdPtrReg <= '0;
        countReg <= '0;
      end else begin
        if (pushValid) wrPtrReg <= wrPtrReg + FIFO_AW'(1);
        if (popValid)  rdPtrReg <= rdPtrReg + FIFO_AW'(1);
        countReg <= countReg + (FIFO_AW+1)'(pushValid) - (FIFO_AW+1)'(popValid);
      end
      if (rdAccept) begin
        rdHoldReg    <= rdValue;
        rdErrHoldReg <= rdErr;
        popSelReg    <= popValid;
      end
      irqReg <= ctrlReg[1] && (32'(countReg) >= 32'(ctrlReg[15:8]));
    end
  end

  // Mailbox storage: no reset so it maps onto block RAM with a registered read
  always_ff @(posedge Clk) begin
    if (pushValid) fifoMem[wrPtrReg] <= vme.VMEWrData;
    if (popValid)  popDataReg        <= fifoMem[rdPtrReg];
  end

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      rdStateReg <= IDLE;
      waitCntReg <= '0;
    end else begin
      rdStateReg <= rdStateNext;
      waitCntReg <= waitCntNext;
    end
  end

  always_comb begin
    rdStateNext    = rdStateReg;
    waitCntNext    = waitCntReg;
    vme.VMERdDone  = 1'b0;
    vme.VMERdError = 1'b0;
    vme.VMERdData  = '0;
    case (rdStateReg)
      IDLE: begin
        if (rdAccept) begin
          waitCntNext = WAIT_LOAD;
          rdStateNext = (RD_WAIT == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        waitCntNext = waitCntReg - 3'd1;
        if (waitCntReg <= 3'd1) rdStateNext = DONE;
      end
      DONE: begin
        rdStateNext    = IDLE;
        vme.VMERdDone  = 1'b1;
        vme.VMERdError = rdErrHoldReg;
        vme.VMERdData  = popSelReg ? popDataReg : rdHoldReg;
      end
      default: rdStateNext = IDLE;
    endcase
  end

  assign vme.VMEWrDone  = wrDoneReg;
  assign vme.VMEWrError = wrErrorReg;
  assign irq_o          = irqReg;
endmodule

// File: tb/tb_vme_reg_responder.sv
// Bench for vme_reg_responder: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level register/FIFO model.
module tb_vme_reg_responder;
  localparam int          RD_WAIT  = 2;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] ID_VALUE = 32'hCAFE0001;

  logic Clk = 1'b0;
  logic rst_n;
  logic irq_o;

  vme_reg_responder_if vme();

  vme_reg_responder #(
    .ID_VALUE(ID_VALUE),
    .RD_WAIT (RD_WAIT),
    .FIFO_AW (4)
  ) dut (
    .Clk  (Clk),
    .rst_n(rst_n),
    .vme  (vme),
    .irq_o(irq_o)
  );

  always #5 Clk = ~Clk;

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference model: register values, FIFO as a queue, expected completions
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rdExp_t;

  logic [31:0] mCtrl, mScratch, mCounter;
  logic [31:0] mFifo[$];
  rdExp_t      rdExpQ[$];
  int          cyc = 0;
  int          rdBusyUntil = -1;
  int          wrDueCyc = -1;
  logic        wrErrExp = 1'b0;
  logic        irqExp = 1'b0;
  logic [31:0] lastRdData = '0;
  logic        lastRdErr = 1'b0;
  logic        lastWrErr = 1'b0;
  int          lastRdCyc = -1;
  int          rdDoneSeen = 0;

  task automatic modelEdge();
    int          w;
    logic [31:0] d;
    logic        e;
    logic [31:0] newCounter;
    if (!rst_n) begin
      mCtrl = '0; mScratch = '0; mCounter = '0;
      mFifo.delete();
      rdExpQ.delete();
      rdBusyUntil = cyc;
      wrDueCyc = -1;
      irqExp = 1'b0;
      return;
    end
    irqExp = mCtrl[1] && (mFifo.size() >= int'(mCtrl[15:8]));
    w = int'(vme.VMEAddr);
    if (vme.VMERdMem && cyc > rdBusyUntil) begin
      d = '0;
      e = 1'b0;
      case (w)
        0: d = ID_VALUE;
        1: d = mCtrl;
        2: d = mScratch;
        3: d = mCounter;
        5: if (mFifo.size() == 0) e = 1'b1; else d = mFifo.pop_front();
        6: d = {14'b0, mFifo.size() == DEPTH, mFifo.size() == 0, 16'(mFifo.size())};
        default: e = 1'b1;
      endcase
      rdExpQ.push_back('{due: cyc + 1 + RD_WAIT, data: d, err: e});
      rdBusyUntil = cyc + 1 + RD_WAIT;
    end
    if (vme.VMEWrMem && w == 7 && vme.VMEWrData[0]) newCounter = '0;
    else if (mCtrl[0])                               newCounter = mCounter + 32'd1;
    else                                             newCounter = mCounter;
    if (vme.VMEWrMem) begin
      e = 1'b0;
      case (w)
        1: mCtrl = vme.VMEWrData;
        2: mScratch = vme.VMEWrData;
        4: if (mFifo.size() < DEPTH) mFifo.push_back(vme.VMEWrData); else e = 1'b1;
        7: if (vme.VMEWrData[1]) mFifo.delete();
        default: e = 1'b1;
      endcase
      wrDueCyc = cyc + 1;
      wrErrExp = e;
    end
    mCounter = newCounter;
  endtask

  task automatic cycle();
    rdExp_t x;
    modelEdge();
    @(posedge Clk);
    #1;
    cyc++;
    if (vme.VMERdDone) begin
      lastRdData = vme.VMERdData;
      lastRdErr  = vme.VMERdError;
      lastRdCyc  = cyc;
      rdDoneSeen++;
    end
    if (vme.VMEWrDone) lastWrErr = vme.VMEWrError;
    if (rdExpQ.size() > 0 && rdExpQ[0].due == cyc) begin
      x = rdExpQ.pop_front();
      checkVal("rd_done", 32'(vme.VMERdDone), 32'd1);
      checkVal("rd_data", vme.VMERdData, x.data);
      checkVal("rd_error", 32'(vme.VMERdError), 32'(x.err));
    end else begin
      checkVal("rd_idle_done", 32'(vme.VMERdDone), 32'd0);
      checkVal("rd_idle_error", 32'(vme.VMERdError), 32'd0);
      checkVal("rd_idle_data", vme.VMERdData, 32'd0);
    end
    if (wrDueCyc == cyc) begin
      checkVal("wr_done", 32'(vme.VMEWrDone), 32'd1);
      checkVal("wr_error", 32'(vme.VMEWrError), 32'(wrErrExp));
    end else begin
      checkVal("wr_idle_done", 32'(vme.VMEWrDone), 32'd0);
      checkVal("wr_idle_error", 32'(vme.VMEWrError), 32'd0);
    end
    checkVal("irq", 32'(irq_o), 32'(irqExp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [10:0] a, input logic [31:0] d);
    vme.VMERdMem  = rd;
    vme.VMEWrMem  = wr;
    vme.VMEAddr   = a;
    vme.VMEWrData = d;
    $display("cyc %0d rd=%0b wr=%0b addr=0x%0h data=%08h", cyc, rd, wr, {a, 2'b00}, d);
    cycle();
    vme.VMERdMem = 1'b0;
    vme.VMEWrMem = 1'b0;
  endtask

  task automatic pulseReset();
    $display("cyc %0d reset", cyc);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int issue;
    int seen;
    rst_n         = 1'b0;
    vme.VMERdMem  = 1'b0;
    vme.VMEWrMem  = 1'b0;
    vme.VMEAddr   = '0;
    vme.VMEWrData = '0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // ID read latency and value
    issue = cyc;
    drive(1'b1, 1'b0, 11'd0, 32'd0);
    idle(3);
    checkVal("id_latency", 32'(lastRdCyc - issue), 32'd3);
    checkVal("id_value", lastRdData, 32'hCAFE0001);
    checkVal("id_error", 32'(lastRdErr), 32'd0);

    // Simultaneous write/read of SCRATCH returns the old value
    drive(1'b1, 1'b1, 11'd2, 32'h12345678);
    idle(3);
    checkVal("scratch_old", lastRdData, 32'd0);
    drive(1'b1, 1'b0, 11'd2, 32'd0);
    idle(3);
    checkVal("scratch_new", lastRdData, 32'h12345678);

    // FIFO fill, overflow, status and drain
    for (int i = 1; i <= 16; i++) drive(1'b0, 1'b1, 11'd4, 32'(i));
    drive(1'b0, 1'b1, 11'd4, 32'd17);
    checkVal("push_full_err", 32'(lastWrErr), 32'd1);
    drive(1'b1, 1'b0, 11'd6, 32'd0);
    idle(3);
    checkVal("fifo_stat_full", lastRdData, 32'h0002_0010);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 11'd5, 32'd0);
      idle(3);
      checkVal("pop_order", lastRdData, 32'(i));
    end
    drive(1'b1, 1'b0, 11'd5, 32'd0);
    idle(3);
    checkVal("pop_empty_err", 32'(lastRdErr), 32'd1);
    checkVal("pop_empty_data", lastRdData, 32'd0);

    // Interrupt threshold of 4
    drive(1'b0, 1'b1, 11'd1, 32'h0000_0403);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 11'd4, 32'hA0 + 32'(i));
    drive(1'b0, 1'b1, 11'd4, 32'hA3);
    checkVal("irq_before", 32'(irq_o), 32'd0);
    cycle();
    checkVal("irq_rise", 32'(irq_o), 32'd1);
    idle(2);
    drive(1'b1, 1'b0, 11'd5, 32'd0);
    checkVal("irq_hold", 32'(irq_o), 32'd1);
    cycle();
    checkVal("irq_fall", 32'(irq_o), 32'd0);
    idle(2);

    // Counter clear followed by an immediate read
    drive(1'b0, 1'b1, 11'd1, 32'h0000_0001);
    idle(6);
    drive(1'b0, 1'b1, 11'd7, 32'h0000_0001);
    drive(1'b1, 1'b0, 11'd3, 32'd0);
    idle(3);
    checkVal("counter_small", 32'(lastRdData < 32'(RD_WAIT + 3)), 32'd1);

    // Reset during a read wait kills the completion
    seen = rdDoneSeen;
    drive(1'b1, 1'b0, 11'd0, 32'd0);
    pulseReset();
    idle(5);
    checkVal("reset_no_done", 32'(rdDoneSeen - seen), 32'd0);
    drive(1'b1, 1'b0, 11'd9, 32'd0);
    idle(3);
    checkVal("unmapped_err", 32'(lastRdErr), 32'd1);
    checkVal("unmapped_data", lastRdData, 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int          sel;
      int          kind;
      logic [10:0] a;
      logic [31:0] d;
      sel  = int'($urandom_range(0, 99));
      a    = (sel < 8) ? 11'($urandom_range(8, 2047)) : 11'($urandom_range(0, 7));
      d    = $urandom;
      if (a == 11'd1) d[15:8] = 8'($urandom_range(0, 18));
      if (a == 11'd7 && sel[0]) d[1] = 1'b0;
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 59) == 0) pulseReset();
      drive(kind != 1, kind != 0, a, d);
      idle(int'($urandom_range(0, 4)));
    end
    idle(8);
    checkVal("rd_pending", 32'(rdExpQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/vme_reg_responder.md
VME_REG_RESPONDER -- requirements
Module: vme_reg_responder

Interface
REQ-001 Parameter ID_VALUE, default 32'hCAFE0001, value returned by the ID register.
REQ-002 Parameter RD_WAIT, default 2, range 0..7, number of wait cycles inserted before a read completes.
REQ-003 Parameter FIFO_AW, default 4, log2 of the mailbox FIFO depth (16 entries).
REQ-004 Port Clk  in  1  the single clock; all logic SHALL be rising-edge triggered.
REQ-005 Port rst_n  in  1  reset, synchronous and active-low.
REQ-006 Port VMEAddr  in  [12:2]  word address, valid with its strobe.
REQ-007 Port VMEWrData  in  32  write data, valid with VMEWrMem.
REQ-008 Port VMERdMem  in  1  one-cycle read strobe.
REQ-009 Port VMEWrMem  in  1  one-cycle write strobe.
REQ-010 Port VMERdData  out  32  read data, valid only while VMERdDone=1.
REQ-011 Port VMERdDone / VMEWrDone  out  1 each  one-cycle completion pulses.
REQ-012 Port VMERdError / VMEWrError  out  1 each  error flags, asserted only together with the matching Done.
REQ-013 Port irq_o  out  1  registered level, 1 while FIFO count >= CTRL[15:8] and CTRL[1]=1.

Function
REQ-014 Register map (byte offsets): 0x00 ID (RO), 0x04 CTRL (RW), 0x08 SCRATCH (RW), 0x0C COUNTER (RO), 0x10 FIFO_W (WO push), 0x14 FIFO_R (RO pop), 0x18 FIFO_STAT (RO), 0x1C CLEAR (WO).
REQ-015 CTRL: bit0 counter enable, bit1 irq enable, [15:8] irq threshold; the other bits are stored and read back unchanged.
REQ-016 COUNTER: 32-bit, increments by 1 each cycle while CTRL[0]=1, wraps 0xFFFFFFFF->0.
REQ-017 FIFO_STAT: [FIFO_AW:0] count, bit 16 empty, bit 17 full; the remaining bits read 0.
REQ-018 Write to CLEAR: data bit0=1 clears COUNTER, bit1=1 flushes the FIFO (count 0); both clears take effect the cycle after the strobe.
REQ-019 Write path: the strobe is accepted in cycle N; the register updates and VMEWrDone pulses in cycle N+1.
REQ-020 Read path: the strobe is accepted in cycle N; the register value is sampled in cycle N into a hold register.
REQ-021 Read path: VMERdDone and VMERdData are presented in cycle N+1+RD_WAIT.
REQ-022 Read FSM states: IDLE -> WAIT (skipped when RD_WAIT=0) -> DONE -> IDLE; a wait counter is loaded with RD_WAIT and decrements in WAIT.
REQ-023 A read strobe received while the read FSM is not IDLE SHALL be ignored: no Done, no side effect.
REQ-024 Read and write paths are independent; a simultaneous read and write are both served.
REQ-025 A read of the same register as a simultaneous write returns the pre-write value.
REQ-026 A FIFO_R pop happens at read accept (cycle N); FIFO_W push happens in cycle N+1.
REQ-027 A push and a pop in the same cycle leave the count unchanged; push into full with concurrent pop is allowed.
REQ-028 Errors (Done still pulses):
- write to ID, COUNTER, FIFO_R or FIFO_STAT -> WrError, no state change;
- read of FIFO_W or CLEAR -> RdError, data 0;
- unmapped address (>=0x20) -> matching Error, read data 0, no side effect;
- push when full without concurrent pop -> WrError, data dropped;
- pop when empty -> RdError, data 0, count stays 0.
REQ-029 VMERdData SHALL be 0 whenever VMERdDone=0.

Reset
REQ-030 When rst_n=0 at a rising edge, the following are zero: CTRL, SCRATCH, COUNTER, FIFO pointers and count, all Done/Error outputs, VMERdData and irq_o.
REQ-031 Reset returns the read FSM to IDLE; a read pending at reset produces no Done.
REQ-032 FIFO storage contents need not be reset.

Verification
REQ-033 Reset, then read ID with RD_WAIT=2 -> VMERdDone exactly 3 cycles after the strobe, data 32'hCAFE0001, VMERdError=0.
REQ-034 Write SCRATCH=0x12345678 simultaneously with a read of SCRATCH -> read returns 0; a subsequent read returns 0x12345678; WrDone 1 cycle after the strobe.
REQ-035 Push 16 words 1..16, then push 17 -> WrError on the 17th write; FIFO_STAT=0x0002_0010; 16 pops return 1..16 in order; a 17th pop gives RdError with data 0.
REQ-036 CTRL=0x0000_0403, push 4 words -> irq_o rises in the cycle after the 4th push lands; one pop -> irq_o falls.
REQ-037 Enable the counter, write CLEAR=1 -> the COUNTER read issued next returns a small value (< RD_WAIT+3).
REQ-038 Assert rst_n=0 during a read WAIT, and separately read 0x24 -> the reset case produces no Done; the 0x24 read gives RdError=1 with data 0.
